regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the LEGv8 datapath, replacing the fixed 32x64, 2-read/1-write file. It adds configurable width, depth and port counts, optional same-cycle write-to-read bypass, a hard-wired zero register, and a per-register busy scoreboard so pipelined issue logic can detect pending writes. It sits between decode (read/issue) and writeback (write), feeding the ALU operand muxes.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- ZERO_REG, 2**ADDR_W-1, index that always reads 0 (XZR = 31 at defaults)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = addressed register has a pending write
- wr_en  in  NUM_WR  write enables (REG_WRITE per port)
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- iss_valid  in  1  issue of an instruction that will write iss_reg
- iss_reg  in  ADDR_W  destination register of the issued instruction

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits; ZERO_REG has no storage, reads 0, never busy.
- Reset (rst=1 at edge): entry i loads i zero-extended to DATA_W (i != ZERO_REG); all busy bits cleared. Writes and issues in a reset cycle are discarded.
- Write: for each port p with wr_en[p]=1 and wr_addr != ZERO_REG, entry updated at edge. Same address on several ports in one cycle: highest-numbered port wins.
- Read: combinational. rd_data[k] = 0 if rd_addr[k]==ZERO_REG; else if BYPASS=1 and any enabled write port targets rd_addr[k] this cycle, that port's wr_data (highest port wins); else stored value.
- rd_busy[k] = busy[rd_addr[k]], combinational. With BYPASS=1 it is 0 when an enabled write to that address is present this cycle and no same-cycle issue targets it.
- Scoreboard, per register: set at edge when iss_valid and iss_reg == index; cleared at edge when any enabled write port targets index. Set and clear in same cycle: set wins (new producer issued after older one completes). iss_reg == ZERO_REG ignored.
- No write-without-busy check: writes to non-busy registers are legal and leave busy at 0.

## Timing
- Read latency 0 cycles (combinational from rd_addr/wr_* to rd_data/rd_busy).
- Write visible through storage on the cycle after the edge; visible same cycle only via bypass (BYPASS=1).
- Busy visible the cycle after issue; cleared the cycle after writeback (or same cycle on rd_busy with BYPASS=1).
- Reset values: all stored entries = index, busy = 0; rd_data/rd_busy follow from addresses (no output registers).
- rst asserted mid-stream: all pending busy bits drop, in-flight writes that cycle lost.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W, ZERO_REG constant (XZR), helper function for highest-priority write-port match.
- One sub-module regfile_scoreboard (busy vector, issue/clear logic, busy lookup per read port); storage and bypass muxes in regfile_mp.

## Test plan
- Reset, then read addr 5 and 31 -> rd_data 5 and 0, rd_busy 0.
- wr_en=01, wr_addr0=3, wr_data0=0xDEAD_BEEF, read addr 3 same cycle -> 0xDEADBEEF with BYPASS=1, 3 with BYPASS=0; next cycle 0xDEADBEEF either way.
- Both ports write addr 7 (0x11, 0x22) -> next cycle reads 0x22; write 0x55 to addr 31 -> reads 0.
- Issue reg 9, next cycle rd_busy=1 on addr 9; write reg 9 -> busy 0 next cycle.
- Issue reg 9 and write reg 9 in the same cycle -> busy stays 1; issue 31 -> busy never set.
- Issue regs 4 and 6, assert rst -> busy all 0, reg 4 reads 4, reg 6 reads 6.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port LEGv8 register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_NUM_WR = 2;
   localparam int XZR        = 31;

   // Upper bound on write ports that the priority helper can arbitrate.
   localparam int MAX_WR     = 32;
   localparam int PORT_IDX_W = $clog2(MAX_WR);

   typedef struct packed {
      logic                  hit;
      logic [PORT_IDX_W-1:0] port;
   } wr_match_t;

   // The highest-numbered port with its hit bit set wins.
   function automatic wr_match_t highest_match(input logic [MAX_WR-1:0] hits);
      wr_match_t m;
      m.hit  = 1'b0;
      m.port = '0;
      for (int p = 0; p < MAX_WR; p++) begin
         if (hits[p]) begin
            m.hit  = 1'b1;
            m.port = PORT_IDX_W'(p);
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, writeback and issue signals of the register file, bundled for the decode/writeback side.
import regfile_pkg::*;

interface regfile_mp_if #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int NUM_WR = DEF_NUM_WR
);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     iss_valid;
   logic [ADDR_W-1:0]        iss_reg;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_reg,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_reg,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: set on issue, cleared on writeback, looked up per read port.
import regfile_pkg::*;

module regfile_scoreboard #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 2**ADDR_W-1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_reg,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int                DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid && iss_reg != ZERO_A) begin
         set_vec[iss_reg] = 1'b1;
      end
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p]) begin
            clr_vec[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   // A fresh issue overrides a completing write: the new producer is still outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= set_vec | (busy & ~clr_vec);
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
         if (BYPASS != 0 && clr_vec[rd_addr[k*ADDR_W +: ADDR_W]]
             && !set_vec[rd_addr[k*ADDR_W +: ADDR_W]]) begin
            rd_busy[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with zero register, optional write bypass and busy scoreboard.
import regfile_pkg::*;

module regfile_mp #(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 2**ADDR_W-1,
   parameter int BYPASS   = 1
) (
   input  logic       clk,
   input  logic       rst,
   regfile_mp_if.slave bus
);

   localparam int                DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [MAX_WR-1:0] hits [NUM_RD];
   wr_match_t         match [NUM_RD];

   // Later ports overwrite earlier ones in the loop, so the highest port wins a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= (i == ZERO_REG) ? '0 : DATA_W'(i);
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && bus.wr_addr[p*ADDR_W +: ADDR_W] != ZERO_A) begin
               mem[bus.wr_addr[p*ADDR_W +: ADDR_W]] <= bus.wr_data[p*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         hits[k] = '0;
         for (int p = 0; p < NUM_WR; p++) begin
            hits[k][p] = bus.wr_en[p]
                         && (bus.wr_addr[p*ADDR_W +: ADDR_W] == bus.rd_addr[k*ADDR_W +: ADDR_W]);
         end
         match[k] = highest_match(hits[k]);
      end
   end

   always_comb begin
      bus.rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (bus.rd_addr[k*ADDR_W +: ADDR_W] == ZERO_A) begin
            bus.rd_data[k*DATA_W +: DATA_W] = '0;
         end else if (BYPASS != 0 && match[k].hit) begin
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wr_data[int'(match[k].port)*DATA_W +: DATA_W];
         end else begin
            bus.rd_data[k*DATA_W +: DATA_W] = mem[bus.rd_addr[k*ADDR_W +: ADDR_W]];
         end
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (bus.rd_addr),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .iss_valid (bus.iss_valid),
      .iss_reg   (bus.iss_reg),
      .rd_busy   (bus.rd_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and checks both
// against an array-based model of the register contents and pending-write flags.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int ZR     = 31;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_b ();
   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_n ();

   regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .ZERO_REG(ZR), .BYPASS(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .ZERO_REG(ZR), .BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   logic                s_rst;
   logic [NUM_WR-1:0]   s_wr_en;
   logic [ADDR_W-1:0]   s_wr_addr [NUM_WR];
   logic [DATA_W-1:0]   s_wr_data [NUM_WR];
   logic                s_iss_valid;
   logic [ADDR_W-1:0]   s_iss_reg;
   logic [ADDR_W-1:0]   s_rd_addr [NUM_RD];

   logic [DATA_W-1:0]   model_mem  [32];
   bit                  model_busy [32];

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearStimulus();
      s_rst       = 1'b0;
      s_wr_en     = '0;
      s_iss_valid = 1'b0;
      s_iss_reg   = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         s_wr_addr[p] = '0;
         s_wr_data[p] = '0;
      end
      for (int k = 0; k < NUM_RD; k++) s_rd_addr[k] = '0;
   endtask

   task automatic applyStimulus();
      rst = s_rst;
      bus_b.wr_en     = s_wr_en;
      bus_n.wr_en     = s_wr_en;
      bus_b.iss_valid = s_iss_valid;
      bus_n.iss_valid = s_iss_valid;
      bus_b.iss_reg   = s_iss_reg;
      bus_n.iss_reg   = s_iss_reg;
      for (int p = 0; p < NUM_WR; p++) begin
         bus_b.wr_addr[p*ADDR_W +: ADDR_W] = s_wr_addr[p];
         bus_n.wr_addr[p*ADDR_W +: ADDR_W] = s_wr_addr[p];
         bus_b.wr_data[p*DATA_W +: DATA_W] = s_wr_data[p];
         bus_n.wr_data[p*DATA_W +: DATA_W] = s_wr_data[p];
      end
      for (int k = 0; k < NUM_RD; k++) begin
         bus_b.rd_addr[k*ADDR_W +: ADDR_W] = s_rd_addr[k];
         bus_n.rd_addr[k*ADDR_W +: ADDR_W] = s_rd_addr[k];
      end
   endtask

   function automatic logic [63:0] rdData(input bit bypass, input int k);
      if (bypass) return bus_b.rd_data[k*DATA_W +: DATA_W];
      return bus_n.rd_data[k*DATA_W +: DATA_W];
   endfunction

   function automatic logic [63:0] rdBusy(input bit bypass, input int k);
      if (bypass) return 64'(bus_b.rd_busy[k]);
      return 64'(bus_n.rd_busy[k]);
   endfunction

   function automatic bit writtenNow(input logic [ADDR_W-1:0] a);
      for (int p = 0; p < NUM_WR; p++) if (s_wr_en[p] && s_wr_addr[p] == a) return 1'b1;
      return 1'b0;
   endfunction

   // The newest write this cycle is the one from the highest port, so search downwards.
   function automatic logic [63:0] expData(input bit bypass, input logic [ADDR_W-1:0] a);
      if (a == ZR) return 64'd0;
      if (bypass) begin
         for (int p = NUM_WR-1; p >= 0; p--) begin
            if (s_wr_en[p] && s_wr_addr[p] == a) return s_wr_data[p];
         end
      end
      return model_mem[a];
   endfunction

   function automatic logic [63:0] expBusy(input bit bypass, input logic [ADDR_W-1:0] a);
      if (a == ZR) return 64'd0;
      if (bypass && writtenNow(a) && !(s_iss_valid && s_iss_reg == a)) return 64'd0;
      return 64'(model_busy[a]);
   endfunction

   task automatic checkModel();
      if (!s_rst) begin
         for (int bp = 0; bp < 2; bp++) begin
            for (int k = 0; k < NUM_RD; k++) begin
               checkOutput($sformatf("c%0d bypass%0d rd%0d data", cycle, bp, k),
                           rdData(bit'(bp), k), expData(bit'(bp), s_rd_addr[k]));
               checkOutput($sformatf("c%0d bypass%0d rd%0d busy", cycle, bp, k),
                           rdBusy(bit'(bp), k), expBusy(bit'(bp), s_rd_addr[k]));
            end
         end
      end
   endtask

   task automatic modelEdge();
      if (s_rst) begin
         for (int i = 0; i < 32; i++) begin
            model_mem[i]  = (i == ZR) ? 64'd0 : 64'(i);
            model_busy[i] = 1'b0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (s_wr_en[p] && s_wr_addr[p] != ZR) model_mem[s_wr_addr[p]] = s_wr_data[p];
            if (s_wr_en[p]) model_busy[s_wr_addr[p]] = 1'b0;
         end
         if (s_iss_valid && s_iss_reg != ZR) model_busy[s_iss_reg] = 1'b1;
      end
   endtask

   task automatic settle();
      applyStimulus();
      #1;
      checkModel();
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelEdge();
      cycle++;
      @(negedge clk);
      clearStimulus();
   endtask

   function automatic logic [ADDR_W-1:0] pickAddr();
      logic [ADDR_W-1:0] hot [4];
      hot[0] = 5'd3; hot[1] = 5'd7; hot[2] = 5'd9; hot[3] = 5'd31;
      if ($urandom_range(0, 1) == 1) return hot[$urandom_range(0, 3)];
      return ADDR_W'($urandom_range(0, 31));
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) begin
         model_mem[i]  = '0;
         model_busy[i] = 1'b0;
      end
      clearStimulus();
      applyStimulus();
      @(negedge clk);

      s_rst = 1'b1; settle(); finishCycle();
      s_rst = 1'b1; settle(); finishCycle();

      s_rd_addr[0] = 5'd5; s_rd_addr[1] = 5'd31; settle();
      checkOutput("reset reg5 data", rdData(1, 0), 64'd5);
      checkOutput("reset xzr data", rdData(1, 1), 64'd0);
      checkOutput("reset reg5 busy", rdBusy(1, 0), 64'd0);
      checkOutput("reset xzr busy", rdBusy(1, 1), 64'd0);
      finishCycle();

      s_wr_en = 2'b01; s_wr_addr[0] = 5'd3; s_wr_data[0] = 64'hDEAD_BEEF; s_rd_addr[0] = 5'd3; settle();
      checkOutput("bypass same cycle", rdData(1, 0), 64'hDEAD_BEEF);
      checkOutput("no bypass same cycle", rdData(0, 0), 64'd3);
      finishCycle();

      s_rd_addr[0] = 5'd3; settle();
      checkOutput("stored after write b", rdData(1, 0), 64'hDEAD_BEEF);
      checkOutput("stored after write n", rdData(0, 0), 64'hDEAD_BEEF);
      finishCycle();

      s_wr_en = 2'b11; s_wr_addr[0] = 5'd7; s_wr_addr[1] = 5'd7;
      s_wr_data[0] = 64'h11; s_wr_data[1] = 64'h22; s_rd_addr[0] = 5'd7; settle();
      checkOutput("bypass collision", rdData(1, 0), 64'h22);
      finishCycle();

      s_rd_addr[0] = 5'd7; s_rd_addr[1] = 5'd31;
      s_wr_en = 2'b01; s_wr_addr[0] = 5'd31; s_wr_data[0] = 64'h55; settle();
      checkOutput("collision high port wins", rdData(0, 0), 64'h22);
      checkOutput("xzr not bypassed", rdData(1, 1), 64'd0);
      finishCycle();

      s_rd_addr[1] = 5'd31; settle();
      checkOutput("xzr after write", rdData(0, 1), 64'd0);
      finishCycle();

      s_iss_valid = 1'b1; s_iss_reg = 5'd9; s_rd_addr[0] = 5'd9; settle();
      checkOutput("busy not yet", rdBusy(0, 0), 64'd0);
      finishCycle();

      s_rd_addr[0] = 5'd9; s_wr_en = 2'b10; s_wr_addr[1] = 5'd9; s_wr_data[1] = 64'h99; settle();
      checkOutput("busy after issue n", rdBusy(0, 0), 64'd1);
      checkOutput("busy bypassed clear b", rdBusy(1, 0), 64'd0);
      finishCycle();

      s_rd_addr[0] = 5'd9; settle();
      checkOutput("busy cleared by write", rdBusy(0, 0), 64'd0);
      finishCycle();

      s_iss_valid = 1'b1; s_iss_reg = 5'd9; s_wr_en = 2'b01; s_wr_addr[0] = 5'd9;
      s_wr_data[0] = 64'hAA; s_rd_addr[0] = 5'd9; settle();
      finishCycle();

      s_rd_addr[0] = 5'd9; s_iss_valid = 1'b1; s_iss_reg = 5'd31; settle();
      checkOutput("issue beats write b", rdBusy(1, 0), 64'd1);
      checkOutput("issue beats write n", rdBusy(0, 0), 64'd1);
      finishCycle();

      s_rd_addr[1] = 5'd31; s_iss_valid = 1'b1; s_iss_reg = 5'd4; settle();
      checkOutput("xzr never busy", rdBusy(0, 1), 64'd0);
      finishCycle();

      s_iss_valid = 1'b1; s_iss_reg = 5'd6; s_rd_addr[0] = 5'd4; settle();
      checkOutput("reg4 busy", rdBusy(0, 0), 64'd1);
      finishCycle();

      s_rst = 1'b1; s_rd_addr[0] = 5'd4; s_rd_addr[1] = 5'd6; settle();
      finishCycle();

      s_rd_addr[0] = 5'd4; s_rd_addr[1] = 5'd6; settle();
      checkOutput("mid reset reg4 data", rdData(0, 0), 64'd4);
      checkOutput("mid reset reg6 data", rdData(0, 1), 64'd6);
      checkOutput("mid reset reg4 busy", rdBusy(0, 0), 64'd0);
      checkOutput("mid reset reg6 busy", rdBusy(0, 1), 64'd0);
      finishCycle();

      for (int n = 0; n < 600; n++) begin
         s_rst       = ($urandom_range(0, 49) == 0);
         s_iss_valid = ($urandom_range(0, 2) != 0);
         s_iss_reg   = pickAddr();
         for (int p = 0; p < NUM_WR; p++) begin
            s_wr_en[p]   = ($urandom_range(0, 1) == 1);
            s_wr_addr[p] = pickAddr();
            s_wr_data[p] = {$urandom, $urandom};
         end
         for (int k = 0; k < NUM_RD; k++) s_rd_addr[k] = pickAddr();
         settle();
         finishCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
